point_word_link: RTL

- DUT-side framing stage that sits between the DUT core and point_master_io.
- TX path: serialises WORD_W-bit words from the core into framed narrow beats on link_o. link_o drives point_master_io data_o.
- RX path: reassembles framed beats arriving on link_i (from point_master_io data_i) into words and buffers them in a FIFO for the core.
- Clocked by the bus clock that point_master_io supplies.

---
 rtl/point_word_link.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/point_word_link.sv
// Word-to-beat framing stage between the DUT core and point_master_io.
// TX serialises words into {valid,last,payload} beats; RX reassembles beats into a FWFT FIFO.
module point_word_link #(
  parameter int WORD_W   = 32,
  parameter int LANE_W   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WORD_W-1:0]   tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [WORD_W-1:0]   rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [LANE_W+1:0]   link_o,
  input  logic [LANE_W+1:0]   link_i,
  output logic                rx_overflow,
  output logic                rx_frame_err
);

  localparam int BEATS = WORD_W / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(RX_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  typedef enum logic {
    RX_ASSEMBLE,
    RX_DISCARD
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t         tx_state;
  logic [BW-1:0]     tx_beat;
  logic [BW-1:0]     tx_next_beat;
  logic [WORD_W-1:0] tx_shift;
  logic              tx_en;
  logic              tx_accept;

  // tx_en keeps tx_ready low while in reset and until the first edge after release
  always_comb begin
    tx_ready     = tx_en & ((tx_state == TX_IDLE) |
                            ((tx_state == TX_SEND) & (tx_beat == LAST_BEAT)));
    tx_accept    = tx_valid & tx_ready;
    tx_next_beat = tx_beat + BW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_beat  <= '0;
      tx_shift <= '0;
      link_o   <= '0;
      tx_en    <= 1'b0;
    end else begin
      tx_en <= 1'b1;
      if (tx_accept) begin
        tx_state <= TX_SEND;
        tx_beat  <= '0;
        tx_shift <= tx_data >> LANE_W;
        link_o   <= {1'b1, (BEATS == 1), tx_data[LANE_W-1:0]};
      end else if (tx_state == TX_SEND) begin
        if (tx_beat == LAST_BEAT) begin
          tx_state <= TX_IDLE;
          link_o   <= '0;
        end else begin
          tx_beat  <= tx_next_beat;
          tx_shift <= tx_shift >> LANE_W;
          link_o   <= {1'b1, (tx_next_beat == LAST_BEAT), tx_shift[LANE_W-1:0]};
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  rx_state_t         rx_state;
  logic [BW-1:0]     rx_cnt;
  logic [WORD_W-1:0] rx_asm;
  logic [WORD_W-1:0] rx_word;
  logic              lnk_valid;
  logic              lnk_last;
  logic [LANE_W-1:0] lnk_payload;
  logic              rx_push;

  always_comb begin
    lnk_valid   = link_i[LANE_W+1];
    lnk_last    = link_i[LANE_W];
    lnk_payload = link_i[LANE_W-1:0];
    // final beat completes the word directly from the link, without passing through rx_asm
    rx_word     = rx_asm;
    rx_word[(BEATS-1)*LANE_W +: LANE_W] = lnk_payload;
    rx_push     = (rx_state == RX_ASSEMBLE) & lnk_valid & lnk_last & (rx_cnt == LAST_BEAT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= RX_ASSEMBLE;
      rx_cnt       <= '0;
      rx_asm       <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_ASSEMBLE: begin
          if (lnk_valid) begin
            if (lnk_last) begin
              if (rx_cnt != LAST_BEAT) rx_frame_err <= 1'b1;
              rx_cnt <= '0;
            end else if (rx_cnt != LAST_BEAT) begin
              rx_asm[32'(rx_cnt)*LANE_W +: LANE_W] <= lnk_payload;
              rx_cnt <= rx_cnt + BW'(1);
            end else begin
              rx_frame_err <= 1'b1;
              rx_cnt       <= '0;
              rx_state     <= RX_DISCARD;
            end
          end
        end
        RX_DISCARD: begin
          if (lnk_valid & lnk_last) begin
            rx_state <= RX_ASSEMBLE;
            rx_cnt   <= '0;
          end
        end
        default: rx_state <= RX_ASSEMBLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [WORD_W-1:0] fifo_mem [RX_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_wr;

  always_comb begin
    rx_valid  = (wr_ptr != rd_ptr);
    fifo_full = (wr_ptr[PW] != rd_ptr[PW]) & (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    fifo_pop  = rx_valid & rx_ready;
    fifo_wr   = rx_push & (~fifo_full | fifo_pop);
    rx_data   = rx_valid ? fifo_mem[rd_ptr[PW-1:0]] : '0;
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) fifo_mem[wr_ptr[PW-1:0]] <= rx_word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (rx_push & ~fifo_wr) rx_overflow <= 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

endmodule
